// File: rtl/gray_window3x3.sv
// rtl/gray_window3x3.sv - builds 3x3 gray pixel neighbourhoods from a raster stream
//
// Ports:
//   clk_i     clock, all logic on the rising edge
//   rst_i     asynchronous active-high reset
//   valid_i   upstream pixel valid
//   ready_o   block can accept a pixel this cycle
//   gray_i    gray pixel, raster order
//   valid_o   window_o holds a valid window
//   ready_i   downstream accepts the window this cycle
//   window_o  tap(r,c) at [(3*r+c)*WIDTH_P +: WIDTH_P]; r=0 oldest row, c=0 leftmost
//   last_o    qualifies valid_o: final window of the frame

module gray_window3x3 #(
    parameter int WIDTH_P      = 8,
    parameter int LINE_WIDTH_P = 640,
    parameter int FRAME_ROWS_P = 480
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH_P-1:0]   gray_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [9*WIDTH_P-1:0] window_o,
    output logic                 last_o
);

    localparam int COL_W = $clog2(LINE_WIDTH_P);
    localparam int ROW_W = $clog2(FRAME_ROWS_P);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE_WIDTH_P - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(FRAME_ROWS_P - 1);
    localparam logic [COL_W-1:0] COL_EMIT0 = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_EMIT0 = ROW_W'(2);

    // Raster position of the next pixel to be accepted.
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;

    // Output stage. The tap registers double as the shifting window.
    logic               valid_q;
    logic               last_q;
    logic [WIDTH_P-1:0] tap_q [9];

    // line0 holds row y-2, line1 holds row y-1 relative to the incoming pixel.
    logic [WIDTH_P-1:0] line0_mem [LINE_WIDTH_P];
    logic [WIDTH_P-1:0] line1_mem [LINE_WIDTH_P];

    logic               accept;
    logic               xfer;
    logic               emit;
    logic               frame_end;
    logic [WIDTH_P-1:0] rd0;
    logic [WIDTH_P-1:0] rd1;

    // The window only advances on accept, and accept is blocked while a window
    // is held (valid_o & ~ready_i), so window_o is stable whenever it must be.
    assign ready_o   = ~valid_q | ready_i;
    assign accept    = valid_i & ready_o;
    assign xfer      = valid_q & ready_i;
    assign emit      = (row_q >= ROW_EMIT0) && (col_q >= COL_EMIT0);
    assign frame_end = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Read-before-write on the same address: the old contents feed the window
    // while the column shifts up one row.
    assign rd0 = line0_mem[col_q];
    assign rd1 = line1_mem[col_q];

    always_ff @(posedge clk_i) begin
        if (accept) begin
            line0_mem[col_q] <= rd1;
            line1_mem[col_q] <= gray_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end

                for (int r = 0; r < 3; r++) begin
                    tap_q[3*r]     <= tap_q[3*r + 1];
                    tap_q[3*r + 1] <= tap_q[3*r + 2];
                end
                tap_q[2] <= rd0;
                tap_q[5] <= rd1;
                tap_q[8] <= gray_i;

                // A new accept always coincides with either no pending window
                // or its transfer, so the new status simply overwrites it.
                valid_q <= emit;
                last_q  <= emit & frame_end;
            end else if (xfer) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;

    for (genvar t = 0; t < 9; t++) begin : g_pack
        assign window_o[t*WIDTH_P +: WIDTH_P] = tap_q[t];
    end

endmodule
